imm_gen_pipe: RTL and testbench

- Registered immediate-generation stage for the pipelined RISC-V core.
- Takes a full 32-bit instruction word plus an immediate-format select and produces the sign- or zero-extended immediate at a parametrised data width (XLEN).
- Adds the CSR zimm (Z) format and an illegal-format flag.
- Sits between the fetch/decode register and the execute operand mux, with a valid/ready handshake and a 2-entry skid buffer so backpressure never combinationally reaches fetch.

---
 rtl/imm_gen_pipe_if.sv | 33 +++
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the registered immediate-generation stage.
// The stage itself uses the slave view; its environment uses the master view.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  // upstream (decode) side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;

  // pipeline control
  logic             flush;

  // downstream (execute operand mux) side
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_inst, in_immsrc, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_immsrc, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator (I/S/B/U/J/Z formats) with a
// 2-entry skid buffer: M drives the outputs, K absorbs one beat of backpressure.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state, state_n;

  logic             in_ready_q;
  logic [XLEN-1:0]  m_imm, k_imm;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic             m_ill, k_ill;

  logic             accept, drain;
  logic             m_load_in, m_load_k, k_load;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_c;
  logic             ill_c;
  logic             unused_opcode;

  assign unused_opcode = ^bus.in_inst[6:0];

  always_comb begin
    imm32 = '0;
    ill_c = 1'b0;
    unique case (bus.in_immsrc)
      3'b000: imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
      3'b001: imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      3'b010: imm32 = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                       bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      3'b011: imm32 = {bus.in_inst[31:12], 12'b0};
      3'b100: imm32 = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                       bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      3'b101: imm32 = {27'b0, bus.in_inst[19:15]};
      default: ill_c = 1'b1;
    endcase
  end

  // Z has bit 31 clear and illegal is all-zero, so one signed widening covers every format.
  assign imm_c = XLEN'($signed(imm32));

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = (state != ST_EMPTY) & bus.out_ready;

  always_comb begin
    state_n   = state;
    m_load_in = 1'b0;
    m_load_k  = 1'b0;
    k_load    = 1'b0;
    if (bus.flush) begin
      state_n = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_load_in = 1'b1;
            state_n   = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept && drain) begin
            m_load_in = 1'b1;
          end else if (accept) begin
            k_load  = 1'b1;
            state_n = ST_FULL;
          end else if (drain) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            m_load_k = 1'b1;
            state_n  = ST_MAIN;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_imm <= '0;
      m_tag <= '0;
      m_ill <= 1'b0;
      k_imm <= '0;
      k_tag <= '0;
      k_ill <= 1'b0;
    end else begin
      if (m_load_in) begin
        m_imm <= imm_c;
        m_tag <= bus.in_tag;
        m_ill <= ill_c;
      end else if (m_load_k) begin
        m_imm <= k_imm;
        m_tag <= k_tag;
        m_ill <= k_ill;
      end
      if (k_load) begin
        k_imm <= imm_c;
        k_tag <= bus.in_tag;
        k_ill <= ill_c;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state != ST_EMPTY);
  assign bus.out_imm     = m_imm;
  assign bus.out_tag     = m_tag;
  assign bus.out_illegal = m_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: format table at XLEN=32 and 64, plus
// backpressure, flush and asynchronous-reset sequences.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [31:0] tag;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  vec_t v32[10];
  vec_t v64[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] tag);
    b32.in_valid  = 1'b1;
    b32.in_inst   = inst;
    b32.in_immsrc = src;
    b32.in_tag    = tag;
    tick();
    b32.in_valid  = 1'b0;
  endtask

  initial begin
    v32[0] = '{32'hFFF00093, 3'b000, 32'h100, 64'hFFFFFFFF, 1'b0};
    v32[1] = '{32'hFE512E23, 3'b001, 32'h101, 64'hFFFFFFFC, 1'b0};
    v32[2] = '{32'h80000063, 3'b010, 32'h102, 64'hFFFFF000, 1'b0};
    v32[3] = '{32'h00000FE3, 3'b010, 32'h103, 64'h0000081E, 1'b0};
    v32[4] = '{32'h123450B7, 3'b011, 32'h104, 64'h12345000, 1'b0};
    v32[5] = '{32'h001000EF, 3'b100, 32'h105, 64'h00000800, 1'b0};
    v32[6] = '{32'h000FD073, 3'b101, 32'h106, 64'h0000001F, 1'b0};
    v32[7] = '{32'hFFFFFFFF, 3'b110, 32'h107, 64'h00000000, 1'b1};
    v32[8] = '{32'hFFFFFFFF, 3'b111, 32'h108, 64'h00000000, 1'b1};
    v32[9] = '{32'hFFF00093, 3'b000, 32'h109, 64'hFFFFFFFF, 1'b0};

    v64[0] = '{32'h800000B7, 3'b011, 32'h200, 64'hFFFFFFFF80000000, 1'b0};
    v64[1] = '{32'hFFF00093, 3'b000, 32'h201, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    v64[2] = '{32'h000FD073, 3'b101, 32'h202, 64'h000000000000001F, 1'b0};

    rst = 1'b1;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_immsrc = '0; b32.in_tag = '0;
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_immsrc = '0; b64.in_tag = '0;
    b64.flush = 1'b0; b64.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
    chk("rst_out_illegal", 64'(b32.out_illegal), 64'd0);
    chk("rst64_out_valid", 64'(b64.out_valid), 64'd0);
    rst = 1'b0;
    tick();

    // back-to-back table at XLEN=32
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        chk($sformatf("v32[%0d].valid", i-1), 64'(b32.out_valid), 64'd1);
        chk($sformatf("v32[%0d].imm", i-1), 64'(b32.out_imm), v32[i-1].imm);
        chk($sformatf("v32[%0d].tag", i-1), 64'(b32.out_tag), 64'(v32[i-1].tag));
        chk($sformatf("v32[%0d].ill", i-1), 64'(b32.out_illegal), 64'(v32[i-1].ill));
        chk($sformatf("v32[%0d].in_ready", i-1), 64'(b32.in_ready), 64'd1);
      end
      if (i < 10) begin
        b32.in_valid  = 1'b1;
        b32.in_inst   = v32[i].inst;
        b32.in_immsrc = v32[i].src;
        b32.in_tag    = v32[i].tag;
      end else begin
        b32.in_valid = 1'b0;
      end
      tick();
    end
    chk("stream_drained", 64'(b32.out_valid), 64'd0);

    // backpressure: A in M, B in K, C refused
    b32.out_ready = 1'b0;
    push32(32'hFFF00093, 3'b000, 32'hA);
    chk("bp_a_valid", 64'(b32.out_valid), 64'd1);
    chk("bp_a_tag", 64'(b32.out_tag), 64'hA);
    chk("bp_a_in_ready", 64'(b32.in_ready), 64'd1);
    push32(32'h123450B7, 3'b011, 32'hB);
    chk("bp_full_tag", 64'(b32.out_tag), 64'hA);
    chk("bp_full_in_ready", 64'(b32.in_ready), 64'd0);
    push32(32'h000FD073, 3'b101, 32'hC);
    chk("bp_hold_tag", 64'(b32.out_tag), 64'hA);
    chk("bp_hold_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    chk("bp_hold_in_ready", 64'(b32.in_ready), 64'd0);
    b32.out_ready = 1'b1;
    tick();
    chk("bp_b_valid", 64'(b32.out_valid), 64'd1);
    chk("bp_b_tag", 64'(b32.out_tag), 64'hB);
    chk("bp_b_imm", 64'(b32.out_imm), 64'h12345000);
    chk("bp_b_in_ready", 64'(b32.in_ready), 64'd1);
    tick();
    chk("bp_c_dropped", 64'(b32.out_valid), 64'd0);

    // flush with both entries full and an input offered
    b32.out_ready = 1'b0;
    push32(32'hFFF00093, 3'b000, 32'hE);
    push32(32'hFFF00093, 3'b000, 32'hF);
    chk("fl_full_in_ready", 64'(b32.in_ready), 64'd0);
    b32.flush = 1'b1;
    push32(32'h123450B7, 3'b011, 32'hD);
    b32.flush = 1'b0;
    chk("fl_full_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_full_in_ready_after", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    tick();
    chk("fl_full_no_ghost", 64'(b32.out_valid), 64'd0);

    // flush beats an acceptance while in_ready=1
    b32.out_ready = 1'b0;
    push32(32'hFFF00093, 3'b000, 32'h6);
    b32.flush = 1'b1;
    push32(32'h123450B7, 3'b011, 32'h7);
    b32.flush = 1'b0;
    chk("fl_main_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_main_in_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    tick();
    chk("fl_main_no_ghost", 64'(b32.out_valid), 64'd0);

    // asynchronous reset with M and K full
    b32.out_ready = 1'b0;
    push32(32'hFFF00093, 3'b000, 32'h8);
    push32(32'hFFF00093, 3'b000, 32'h9);
    chk("ar_pre_full", 64'(b32.in_ready), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(b32.out_valid), 64'd0);
    chk("ar_in_ready", 64'(b32.in_ready), 64'd1);
    chk("ar_out_imm", 64'(b32.out_imm), 64'd0);
    chk("ar_out_tag", 64'(b32.out_tag), 64'd0);
    #1;
    rst = 1'b0;
    b32.out_ready = 1'b1;
    tick();
    chk("ar_after_valid", 64'(b32.out_valid), 64'd0);

    // back-to-back table at XLEN=64
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        chk($sformatf("v64[%0d].valid", i-1), 64'(b64.out_valid), 64'd1);
        chk($sformatf("v64[%0d].imm", i-1), b64.out_imm, v64[i-1].imm);
        chk($sformatf("v64[%0d].tag", i-1), 64'(b64.out_tag), 64'(v64[i-1].tag));
        chk($sformatf("v64[%0d].ill", i-1), 64'(b64.out_illegal), 64'(v64[i-1].ill));
      end
      if (i < 3) begin
        b64.in_valid  = 1'b1;
        b64.in_inst   = v64[i].inst;
        b64.in_immsrc = v64[i].src;
        b64.in_tag    = v64[i].tag;
      end else begin
        b64.in_valid = 1'b0;
      end
      tick();
    end
    chk("v64_drained", 64'(b64.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
